// File: rtl/sha1_pkg.sv
// Shared constants, types and round functions for the memory-mapped SHA-1 accelerator.
package sha1_pkg;

    localparam logic [31:0] SHA1_IV [5] = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                            32'h10325476, 32'hC3D2E1F0};
    localparam logic [31:0] K_00_19 = 32'h5A827999;
    localparam logic [31:0] K_20_39 = 32'h6ED9EBA1;
    localparam logic [31:0] K_40_59 = 32'h8F1BBCDC;
    localparam logic [31:0] K_60_79 = 32'hCA62C1D6;

    localparam int CTRL     = 0;
    localparam int MSG_BASE = 1;
    localparam int DIG_BASE = 17;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_CLR    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL
    } sha1_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_work_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)      return (b & c) | (~b & d);
        else if (t < 7'd40) return b ^ c ^ d;
        else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
        else                return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        if (t < 7'd20)      return K_00_19;
        else if (t < 7'd40) return K_20_39;
        else if (t < 7'd60) return K_40_59;
        else                return K_60_79;
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round; chained several times per clock by the top level.
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_work_t  i_work,
    input  logic [31:0] i_w,
    input  logic [6:0]  i_t,
    output sha1_work_t  o_work
);
    logic [31:0] w_temp;

    assign w_temp   = rotl(i_work.a, 5) + sha1_f(i_t, i_work.b, i_work.c, i_work.d)
                    + i_work.e + sha1_k(i_t) + i_w;
    assign o_work.a = w_temp;
    assign o_work.b = i_work.a;
    assign o_work.c = rotl(i_work.b, 30);
    assign o_work.d = i_work.c;
    assign o_work.e = i_work.d;

endmodule

// File: rtl/sha1_mm_accel.sv
// Bus-slave register file around an iterative SHA-1 engine with block chaining,
// ROUNDS_PER_CYCLE rounds per clock, sticky done/err flags and a level interrupt.
module sha1_mm_accel
    import sha1_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int ADDR_WIDTH       = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq
);
    localparam int         R         = ROUNDS_PER_CYCLE;
    localparam logic [6:0] LAST_STEP = 7'(80 - R);

    generate
        if (!(R == 1 || R == 2 || R == 4 || R == 5)) begin : g_bad_rounds
            $error("sha1_mm_accel: ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
        end
        if (ADDR_WIDTH < 5) begin : g_bad_addr
            $error("sha1_mm_accel: ADDR_WIDTH must be at least 5");
        end
    endgenerate

    sha1_state_e r_state;
    sha1_work_t  r_work;
    logic [31:0] r_msg [16];
    logic [31:0] r_w [16];
    logic [31:0] r_h [5];
    logic [6:0]  r_round;
    logic        r_done;
    logic        r_err;
    logic        r_irq_en;
    logic [15:0] r_blk_cnt;
    logic [31:0] r_readdata;

    logic        w_busy;
    logic        w_is_ctrl;
    logic        w_is_msg;
    logic        w_is_dig;
    logic [3:0]  w_msg_idx;
    logic [2:0]  w_dig_idx;
    logic [31:0] w_rdata;
    logic [31:0] w_sched [16+R];

    assign w_busy    = (r_state != ST_IDLE);
    assign w_is_ctrl = (address == ADDR_WIDTH'(CTRL));
    assign w_is_msg  = (address >= ADDR_WIDTH'(MSG_BASE)) && (address < ADDR_WIDTH'(DIG_BASE));
    assign w_is_dig  = (address >= ADDR_WIDTH'(DIG_BASE)) && (address < ADDR_WIDTH'(DIG_BASE + 5));
    assign w_msg_idx = 4'(address - ADDR_WIDTH'(MSG_BASE));
    assign w_dig_idx = 3'(address - ADDR_WIDTH'(DIG_BASE));
    assign readdata  = r_readdata;
    assign irq       = r_done & r_irq_en;

    always_comb begin
        w_rdata = '0;
        if (w_is_ctrl)     w_rdata = {r_blk_cnt, 12'h000, r_err, r_irq_en, r_done, w_busy};
        else if (w_is_msg) w_rdata = r_msg[w_msg_idx];
        else if (w_is_dig) w_rdata = r_h[w_dig_idx];
    end

    // Schedule words for this cycle's R rounds: w_sched[j] is W[t+j], extended past 15 as needed.
    always_comb begin
        for (int i = 0; i < 16; i++) w_sched[i] = r_w[i];
        for (int i = 16; i < 16 + R; i++)
            w_sched[i] = rotl(w_sched[i-3] ^ w_sched[i-8] ^ w_sched[i-14] ^ w_sched[i-16], 1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_round
            sha1_work_t w_in;
            sha1_work_t w_out;
            if (gi == 0) begin : g_head
                assign w_in = r_work;
            end else begin : g_link
                assign w_in = g_round[gi-1].w_out;
            end
            sha1_round u_round (
                .i_work (w_in),
                .i_w    (w_sched[gi]),
                .i_t    (r_round + 7'(gi)),
                .o_work (w_out)
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_work     <= '0;
            r_round    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_blk_cnt  <= '0;
            r_readdata <= '0;
            for (int i = 0; i < 16; i++) begin
                r_msg[i] <= '0;
                r_w[i]   <= '0;
            end
            for (int i = 0; i < 5; i++) r_h[i] <= SHA1_IV[i];
        end else begin
            if (read) r_readdata <= w_rdata;

            // CLR is applied before START, so a combined write clears and then starts.
            if (write && w_is_ctrl) begin
                r_irq_en <= writedata[CTRL_IRQ_EN];
                if (writedata[CTRL_CLR]) begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                end
                if (writedata[CTRL_START]) begin
                    if (w_busy) begin
                        r_err <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_LOAD;
                        if (!writedata[CTRL_CONT]) begin
                            for (int i = 0; i < 5; i++) r_h[i] <= SHA1_IV[i];
                            r_blk_cnt <= '0;
                        end
                    end
                end
            end else if (write && w_is_msg) begin
                if (w_busy) r_err <= 1'b1;
                else        r_msg[w_msg_idx] <= writedata;
            end

            case (r_state)
                ST_LOAD: begin
                    for (int i = 0; i < 16; i++) r_w[i] <= r_msg[i];
                    r_work  <= '{a: r_h[0], b: r_h[1], c: r_h[2], d: r_h[3], e: r_h[4]};
                    r_round <= '0;
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_work <= g_round[R-1].w_out;
                    for (int i = 0; i < 16; i++) r_w[i] <= w_sched[i+R];
                    r_round <= r_round + 7'(R);
                    if (r_round == LAST_STEP) r_state <= ST_FINAL;
                end
                ST_FINAL: begin
                    r_h[0]    <= r_h[0] + r_work.a;
                    r_h[1]    <= r_h[1] + r_work.b;
                    r_h[2]    <= r_h[2] + r_work.c;
                    r_h[3]    <= r_h[3] + r_work.d;
                    r_h[4]    <= r_h[4] + r_work.e;
                    r_blk_cnt <= r_blk_cnt + 16'd1;
                    r_done    <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_mm_accel.sv
// Self-checking bench: four accelerators (1, 2, 4, 5 rounds per cycle) share one bus
// and are checked against known SHA-1 digests, status words and done latency.
module tb_sha1_mm_accel;
    localparam int NDUT = 4;

    localparam logic [511:0] MSG_ABC = {32'h61626380, 448'h0, 32'h00000018};
    // 56-byte message: the 0x80 pad byte still fits in block 1, the length goes in block 2.
    localparam logic [511:0] MSG_2A  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] MSG_2B  = {480'h0, 32'h000001C0};
    localparam logic [159:0] DIG_ABC = {32'hA9993E36, 32'h4706816A, 32'hBA3E2571,
                                        32'h7850C26C, 32'h9CD0D89D};
    localparam logic [159:0] DIG_2   = {32'h84983E44, 32'h1C3BD26E, 32'hBAAE4AA1,
                                        32'hF95129E5, 32'hE54670F1};
    localparam logic [159:0] DIG_IV  = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                        32'h10325476, 32'hC3D2E1F0};

    typedef struct {
        string          name;
        logic [511:0]   msg;
        logic           cont;
        logic           chk_dig;
        logic [159:0]   dig;
        logic [15:0]    cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [4:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] rdata [NDUT];
    logic        irq_w [NDUT];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rpc_of(input int i);
        return (i == 3) ? 5 : (1 << i);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            sha1_mm_accel #(.ROUNDS_PER_CYCLE(rpc_of(gi)), .ADDR_WIDTH(5)) u_dut (
                .clk       (clk),
                .reset_n   (reset_n),
                .write     (write),
                .read      (read),
                .address   (address),
                .writedata (writedata),
                .readdata  (rdata[gi]),
                .irq       (irq_w[gi])
            );
        end
    endgenerate

    function automatic logic [31:0] stat(input logic busy, input logic done, input logic ien,
                                         input logic err, input logic [15:0] cnt);
        return {cnt, 12'h000, err, ien, done, busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [31:0] exp);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s r%0d", name, rpc_of(k)), rdata[k], exp);
    endtask

    task automatic check_irq(input string name, input logic exp);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s r%0d", name, rpc_of(k)), 32'(irq_w[k]), 32'(exp));
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a);
        @(negedge clk);
        read = 1'b1; address = a;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus_read(a);
        check_all(name, exp);
    endtask

    task automatic load_msg(input logic [511:0] m);
        for (int i = 0; i < 16; i++) bus_write(5'(i + 1), m[511 - 32*i -: 32]);
    endtask

    task automatic check_digest(input string name, input logic [159:0] d);
        for (int i = 0; i < 5; i++)
            rd_check($sformatf("%s H%0d", name, i), 5'(17 + i), d[159 - 32*i -: 32]);
    endtask

    task automatic start(input logic [31:0] ctrl);
        bus_write(5'd0, ctrl);
        start_cyc = cyc;
    endtask

    // Needs IRQ_EN set: records the cycle each DUT's irq first rises and checks latency.
    task automatic wait_irq(input string name);
        bit all_seen;
        for (int k = 0; k < NDUT; k++) done_cyc[k] = -1;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            all_seen = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                if (irq_w[k] && done_cyc[k] < 0) done_cyc[k] = cyc;
                if (done_cyc[k] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s latency r%0d", name, rpc_of(k)),
                  32'(done_cyc[k] - start_cyc), 32'(2 + 80 / rpc_of(k)));
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 100 && !idle; n++) begin
            bus_read(5'd0);
            idle = 1'b1;
            for (int k = 0; k < NDUT; k++) if (rdata[k][0]) idle = 1'b0;
        end
        check({name, " idle before timeout"}, 32'(idle), 32'd1);
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{"abc",          MSG_ABC, 1'b0, 1'b1, DIG_ABC, 16'd1};
        vecs[1] = '{"two-block b1", MSG_2A,  1'b0, 1'b0, DIG_2,   16'd1};
        vecs[2] = '{"two-block b2", MSG_2B,  1'b1, 1'b1, DIG_2,   16'd2};
        vecs[3] = '{"abc again",    MSG_ABC, 1'b0, 1'b1, DIG_ABC, 16'd1};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check_all("readdata after reset", 32'h0);
        check_irq("irq after reset", 1'b0);
        rd_check("ctrl after reset", 5'd0, 32'h0);
        check_digest("reset", DIG_IV);
        rd_check("W15 after reset", 5'd16, 32'h0);
        rd_check("unmapped addr", 5'd25, 32'h0);
        $display("reset state checked");

        // Read and write of the same word in one cycle returns the old value
        @(negedge clk);
        write = 1'b1; read = 1'b1; address = 5'd1; writedata = 32'h12345678;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        check_all("rw same cycle old", 32'h0);
        rd_check("rw same cycle new", 5'd1, 32'h12345678);
        bus_write(5'd30, 32'hFFFFFFFF);
        rd_check("ignored write ctrl", 5'd0, 32'h0);
        $display("simultaneous read/write checked");

        for (int v = 0; v < 4; v++) begin
            load_msg(vecs[v].msg);
            start(32'h5 | (32'(vecs[v].cont) << 1));
            wait_irq(vecs[v].name);
            check_irq({vecs[v].name, " irq"}, 1'b1);
            rd_check({vecs[v].name, " status"}, 5'd0, stat(1'b0, 1'b1, 1'b1, 1'b0, vecs[v].cnt));
            if (vecs[v].chk_dig) check_digest(vecs[v].name, vecs[v].dig);
            $display("vector %s: block count %0d", vecs[v].name, vecs[v].cnt);
        end

        // Writes while busy are dropped and flag err
        start(32'h1);
        bus_write(5'd4, 32'hDEADBEEF);
        bus_write(5'd0, 32'h1);
        rd_check("busy err status", 5'd0, stat(1'b1, 1'b0, 1'b0, 1'b1, 16'd0));
        wait_idle("err run");
        rd_check("err kept after done", 5'd0, stat(1'b0, 1'b1, 1'b0, 1'b1, 16'd1));
        rd_check("W3 unchanged", 5'd4, 32'h0);
        check_digest("abc with err", DIG_ABC);
        bus_write(5'd0, 32'h8);
        rd_check("clr status", 5'd0, stat(1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        $display("busy-write error sequence checked");

        // Interrupt gating
        start(32'h5);
        wait_irq("irq run");
        bus_write(5'd0, 32'hC);
        check_irq("irq after clr", 1'b0);
        rd_check("irq_en kept", 5'd0, stat(1'b0, 1'b0, 1'b1, 1'b0, 16'd1));
        start(32'h1);
        wait_idle("no-irq run");
        check_irq("irq disabled while done", 1'b0);
        rd_check("done without irq_en", 5'd0, stat(1'b0, 1'b1, 1'b0, 1'b0, 16'd1));
        bus_write(5'd0, 32'h4);
        check_irq("irq on enable", 1'b1);
        bus_write(5'd0, 32'h8);
        check_irq("irq after disable clr", 1'b0);
        $display("interrupt sequence checked");

        // Reset mid-hash
        start(32'h5);
        repeat (41) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all("readdata in reset", 32'h0);
        check_irq("irq in reset", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_check("ctrl after abort", 5'd0, 32'h0);
        check_digest("abort", DIG_IV);
        rd_check("W0 after abort", 5'd1, 32'h0);
        load_msg(MSG_ABC);
        start(32'h5);
        wait_irq("post-abort");
        rd_check("post-abort status", 5'd0, stat(1'b0, 1'b1, 1'b1, 1'b0, 16'd1));
        check_digest("post-abort", DIG_ABC);
        $display("reset mid-hash sequence checked");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
